stream_rr_arbiter: RTL and testbench
====================================

Name: stream_rr_arbiter

Overview:
- Round-robin arbiter for N_INP valid/ready streams onto one output stream.
- Owns arbitration state: rotating priority pointer and a grant lock. Exports the winning index so downstream logic can tag or route the transfer.
- Sits directly upstream of a select-driven stream multiplexer, or replaces one where the select must be computed fairly.
- Zero-latency datapath: data, valid and ready pass combinationally; only arbitration state is registered.

Parameters:
- DATA_T, logic, payload type of each stream.
- N_INP, 2, number of input streams; must be >= 1.
- IDX_W, (N_INP > 1) ? $clog2(N_INP) : 1, index width. Dependent parameter; do not override.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- inp_data_i  input  N_INP x DATA_T  input payloads.
- inp_valid_i  input  N_INP  input valids.
- inp_ready_o  output  N_INP  input readys; at most one bit is high (one-hot or zero).
- oup_data_o  output  DATA_T  payload of the granted input.
- oup_valid_o  output  1  output valid.
- oup_ready_i  input  1  output ready.
- oup_sel_o  output  IDX_W  index of the granted input; valid whenever oup_valid_o is high.

Behaviour:
- State: rr_q (IDX_W, next-highest-priority index), lock_q (1 bit), lock_idx_q (IDX_W).
- Reset (rst_i high at a clock edge): rr_q=0, lock_q=0, lock_idx_q=0.
- While rst_i is high, outputs are forced: oup_valid_o=0, inp_ready_o='0, oup_sel_o=0, oup_data_o=inp_data_i[0].
- Grant selection (combinational):
  - If lock_q=1, grant=lock_idx_q.
  - Otherwise, grant is the first i with inp_valid_i[i]=1, scanning cyclically rr_q, rr_q+1, ..., N_INP-1, 0, ..., rr_q-1.
  - If no input is valid, grant=rr_q.
- Outputs:
  - oup_sel_o=grant, oup_data_o=inp_data_i[grant], oup_valid_o=inp_valid_i[grant].
  - inp_ready_o[grant]=oup_ready_i; all other bits are 0.
- Handshake is oup_valid_o & oup_ready_i. On handshake:
  - rr_q <= grant+1, wrapping to 0 when grant=N_INP-1. Wrap is explicit, so non-power-of-two N_INP never yields an index >= N_INP.
  - lock_q <= 0.
- Stall is oup_valid_o & ~oup_ready_i. On stall: lock_q <= 1, lock_idx_q <= grant, rr_q unchanged.
  - Consequence: once valid is presented, the output stream keeps the same source and data until accepted (stream stability rule). A higher-priority input arriving later does not pre-empt.
- Idle (oup_valid_o=0): no state change.
- Fairness: any continuously valid input is granted within N_INP handshakes.
- Locked-input protocol violation (inp_valid_i[lock_idx_q] drops before handshake):
  - lock is retained; oup_valid_o follows the input low.
  - simulation-only assertion fires; RTL takes no recovery action.
- N_INP=1: degenerates to a pass-through. rr_q and lock_idx_q stay 0; oup_sel_o=0.
- Reset mid-transfer: lock and pointer are cleared on the reset edge. The first cycle after reset arbitrates from index 0 regardless of the prior lock.
- Simulation-only assertions:
  - N_INP >= 1 (fatal at elaboration).
  - $onehot0(inp_ready_o).
  - oup_data_o stable while oup_valid_o & ~oup_ready_i.

Decomposition:
- No shared package; all widths derive from parameters, and DATA_T is supplied by the instantiator.
- One combinational sub-module, rr_prio_pick (params N_INP, IDX_W).
  - Inputs: req vector, start index.
  - Outputs: granted index, any-valid flag.
  - Implementation: rotate, leading-zero-count, un-rotate with modulo N_INP.
  - Reusable by other arbiters in the codebase.
- Top level holds the lock/pointer registers and the data/ready muxing.

Test Plan:
- N_INP=4, all valid, oup_ready_i=1 continuously -> oup_sel_o sequence 0,1,2,3,0,1; rr_q wraps 3->0.
- N_INP=3, all valid, ready=1 -> sel 0,1,2,0; rr_q never reaches 3.
- N_INP=4, inputs 1 and 3 valid with data 0xA1/0xA3, ready=0 for 3 cycles then 1:
  - sel=1 and data=0xA1 held stable all 4 cycles; handshake on cycle 4.
  - next grant is 3.
- N_INP=4, stall on input 2; input 0 becomes valid during the stall -> grant stays 2 until handshake, then 3 if valid, else 0.
- rst_i asserted during a stall locked on input 2 -> lock cleared; first post-reset grant is the lowest valid index >= 0; oup_valid_o=0 while rst_i is high.
- N_INP=1, random valid/ready -> inp_ready_o[0]==oup_ready_i; oup_sel_o==0; data passes through with zero latency.

Source files
------------

// File: rtl/rr_prio_pick.sv
// Cyclic priority picker: first set request at or after a start index, wrapping modulo N_INP.
// Purely combinational so any arbiter can wrap its own pointer/lock state around it.
module rr_prio_pick #(
  parameter int unsigned N_INP = 2,
  parameter int unsigned IDX_W = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic [N_INP-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  // start is always < N_INP, so a single conditional subtract is a full modulo
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b);
    int unsigned s;
    s = a + b;
    return (s >= N_INP) ? s - N_INP : s;
  endfunction

  logic [N_INP-1:0] rot;
  int unsigned      off;
  logic             found;

  always_comb begin
    rot   = '0;
    off   = 0;
    found = 1'b0;
    idx_c = start;
    any_c = 1'b0;
    for (int unsigned i = 0; i < N_INP; i++) begin
      rot[i] = req[IDX_W'(wrap_add(int'(start), i))];
    end
    for (int unsigned i = 0; i < N_INP; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    if (found) begin
      idx_c = IDX_W'(wrap_add(int'(start), off));
    end
    any_c = found;
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging N_INP valid/ready streams onto one output stream.
// Datapath is combinational; only the rotating pointer and stall lock are registered.
module stream_rr_arbiter #(
  parameter type         DATA_T = logic,
  parameter int unsigned N_INP  = 2,
  parameter int unsigned IDX_W  = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  DATA_T            inp_data_i [N_INP],
  input  logic [N_INP-1:0] inp_valid_i,
  output logic [N_INP-1:0] inp_ready_o,
  output DATA_T            oup_data_o,
  output logic             oup_valid_o,
  input  logic             oup_ready_i,
  output logic [IDX_W-1:0] oup_sel_o
);

  logic [IDX_W-1:0] rr_q;
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx_q;

  logic [IDX_W-1:0] pick_idx_c;
  logic             pick_any_c;
  logic [IDX_W-1:0] grant_c;
  logic [IDX_W-1:0] rr_next_c;

  rr_prio_pick #(
    .N_INP (N_INP),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (inp_valid_i),
    .start (rr_q),
    .idx_c (pick_idx_c),
    .any_c (pick_any_c)
  );

  // Locked grant keeps the stalled source on the output until it is accepted
  always_comb begin
    grant_c   = pick_idx_c;
    rr_next_c = '0;
    if (lock_q) begin
      grant_c = lock_idx_q;
    end
    if (grant_c != IDX_W'(N_INP - 1)) begin
      rr_next_c = grant_c + IDX_W'(1);
    end
  end

  always_comb begin
    oup_sel_o            = grant_c;
    oup_data_o           = inp_data_i[grant_c];
    oup_valid_o          = lock_q ? inp_valid_i[lock_idx_q] : pick_any_c;
    inp_ready_o          = '0;
    inp_ready_o[grant_c] = oup_ready_i;
    if (rst_i) begin
      oup_sel_o   = '0;
      oup_data_o  = inp_data_i[0];
      oup_valid_o = 1'b0;
      inp_ready_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (oup_valid_o) begin
      if (oup_ready_i) begin
        rr_q   <= rr_next_c;
        lock_q <= 1'b0;
      end else begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant_c;
      end
    end
  end

`ifndef SYNTHESIS
  if (N_INP < 1) begin : g_bad_n_inp
    $fatal(1, "stream_rr_arbiter: N_INP must be >= 1");
  end

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(inp_ready_o));

  a_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (oup_valid_o && !oup_ready_i) |=> $stable(oup_data_o));

  a_locked_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
    lock_q |-> inp_valid_i[lock_idx_q]);
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter at N_INP = 4, 3 and 1.
module tb_stream_rr_arbiter;

  typedef logic [7:0] data_t;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       rdy;
    int         sel;
    logic       ov;
    logic [3:0] ir;
  } vec_t;

  typedef struct {
    int sel;
    int ov;
    int data;
    int ir;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_t       d4 [4];
  logic [3:0]  v4 = '0;
  logic [3:0]  ir4;
  data_t       od4;
  logic        ov4;
  logic        or4 = 1'b0;
  logic [1:0]  s4;

  data_t       d3 [3];
  logic [2:0]  v3 = '0;
  logic [2:0]  ir3;
  data_t       od3;
  logic        ov3;
  logic        or3 = 1'b0;
  logic [1:0]  s3;

  data_t       d1 [1];
  logic [0:0]  v1 = '0;
  logic [0:0]  ir1;
  data_t       od1;
  logic        ov1;
  logic        or1 = 1'b0;
  logic [0:0]  s1;

  stream_rr_arbiter #(.DATA_T(data_t), .N_INP(4)) u4 (
    .clk_i(clk), .rst_i(rst), .inp_data_i(d4), .inp_valid_i(v4), .inp_ready_o(ir4),
    .oup_data_o(od4), .oup_valid_o(ov4), .oup_ready_i(or4), .oup_sel_o(s4)
  );

  stream_rr_arbiter #(.DATA_T(data_t), .N_INP(3)) u3 (
    .clk_i(clk), .rst_i(rst), .inp_data_i(d3), .inp_valid_i(v3), .inp_ready_o(ir3),
    .oup_data_o(od3), .oup_valid_o(ov3), .oup_ready_i(or3), .oup_sel_o(s3)
  );

  stream_rr_arbiter #(.DATA_T(data_t), .N_INP(1)) u1 (
    .clk_i(clk), .rst_i(rst), .inp_data_i(d1), .inp_valid_i(v1), .inp_ready_o(ir1),
    .oup_data_o(od1), .oup_valid_o(ov1), .oup_ready_i(or1), .oup_sel_o(s1)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb [$];
  vec_t t4 [$];
  vec_t t3 [$];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic rdy,
                              input int sel, input logic ov, input logic [3:0] ir);
    vec_t t;
    t.rst = r; t.v = v; t.rdy = rdy; t.sel = sel; t.ov = ov; t.ir = ir;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one vector after the edge, queue its expectation, compare mid-cycle
  task automatic apply(input int dut, input vec_t t, input string tag);
    exp_t e;
    exp_t a;
    int   base;
    @(posedge clk);
    #1;
    rst = t.rst;
    if (dut == 4) begin
      v4 = t.v; or4 = t.rdy; base = 'hA0;
    end else begin
      v3 = t.v[2:0]; or3 = t.rdy; base = 'hB0;
    end
    e.sel  = t.sel;
    e.ov   = int'(t.ov);
    e.ir   = int'(t.ir);
    e.data = t.rst ? base : base + t.sel;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    if (dut == 4) begin
      a.sel = int'(s4); a.ov = int'(ov4); a.data = int'(od4); a.ir = int'(ir4);
    end else begin
      a.sel = int'(s3); a.ov = int'(ov3); a.data = int'(od3); a.ir = int'(ir3);
    end
    check({tag, ".sel"},   a.sel,  e.sel);
    check({tag, ".valid"}, a.ov,   e.ov);
    check({tag, ".data"},  a.data, e.data);
    check({tag, ".ready"}, a.ir,   e.ir);
  endtask

  initial begin
    logic prev_stall;
    exp_t e;

    for (int i = 0; i < 4; i++) d4[i] = data_t'('hA0 + i);
    for (int i = 0; i < 3; i++) d3[i] = data_t'('hB0 + i);
    d1[0] = 8'h00;

    // N_INP=4: reset, full rotation with wrap, stall hold, no pre-emption, idle
    t4.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000));
    t4.push_back(mk(0, 4'b1111, 1, 0, 1, 4'b0001));
    t4.push_back(mk(0, 4'b1111, 1, 1, 1, 4'b0010));
    t4.push_back(mk(0, 4'b1111, 1, 2, 1, 4'b0100));
    t4.push_back(mk(0, 4'b1111, 1, 3, 1, 4'b1000));
    t4.push_back(mk(0, 4'b1111, 1, 0, 1, 4'b0001));
    t4.push_back(mk(0, 4'b1111, 1, 1, 1, 4'b0010));
    t4.push_back(mk(1, 4'b1111, 1, 0, 0, 4'b0000));
    t4.push_back(mk(0, 4'b1010, 0, 1, 1, 4'b0000));
    t4.push_back(mk(0, 4'b1010, 0, 1, 1, 4'b0000));
    t4.push_back(mk(0, 4'b1010, 0, 1, 1, 4'b0000));
    t4.push_back(mk(0, 4'b1010, 1, 1, 1, 4'b0010));
    t4.push_back(mk(0, 4'b1010, 1, 3, 1, 4'b1000));
    t4.push_back(mk(0, 4'b0010, 1, 1, 1, 4'b0010));
    t4.push_back(mk(0, 4'b0100, 0, 2, 1, 4'b0000));
    t4.push_back(mk(0, 4'b0101, 0, 2, 1, 4'b0000));
    t4.push_back(mk(0, 4'b0101, 1, 2, 1, 4'b0100));
    t4.push_back(mk(0, 4'b0001, 1, 0, 1, 4'b0001));
    t4.push_back(mk(0, 4'b0000, 1, 1, 0, 4'b0010));
    t4.push_back(mk(0, 4'b1001, 1, 3, 1, 4'b1000));
    t4.push_back(mk(0, 4'b1001, 1, 0, 1, 4'b0001));

    // N_INP=3: pointer wraps 2->0 and never reaches 3
    t3.push_back(mk(0, 4'b0111, 1, 0, 1, 4'b0001));
    t3.push_back(mk(0, 4'b0111, 1, 1, 1, 4'b0010));
    t3.push_back(mk(0, 4'b0111, 1, 2, 1, 4'b0100));
    t3.push_back(mk(0, 4'b0111, 1, 0, 1, 4'b0001));
    t3.push_back(mk(0, 4'b0111, 1, 1, 1, 4'b0010));
    t3.push_back(mk(0, 4'b0000, 0, 2, 0, 4'b0000));
    t3.push_back(mk(0, 4'b0101, 1, 2, 1, 4'b0100));
    t3.push_back(mk(0, 4'b0101, 1, 0, 1, 4'b0001));

    repeat (2) @(posedge clk);

    foreach (t4[i]) apply(4, t4[i], $sformatf("n4[%0d]", i));

    // Reset arriving while locked on input 2 clears the lock
    apply(4, mk(0, 4'b0100, 0, 2, 1, 4'b0000), "rst_seq.lock2");
    apply(4, mk(1, 4'b0101, 1, 0, 0, 4'b0000), "rst_seq.rst0");
    apply(4, mk(1, 4'b0101, 1, 0, 0, 4'b0000), "rst_seq.rst1");
    apply(4, mk(0, 4'b0110, 1, 1, 1, 4'b0010), "rst_seq.post");
    @(posedge clk);
    #1;
    v4 = '0;

    foreach (t3[i]) apply(3, t3[i], $sformatf("n3[%0d]", i));
    @(posedge clk);
    #1;
    v3 = '0;

    // N_INP=1: random pass-through, valid/data held across stalls
    prev_stall = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      if (!prev_stall) begin
        v1[0] = 1'($urandom);
        d1[0] = 8'($urandom);
      end
      or1 = 1'($urandom);
      e.sel = 0; e.ov = int'(v1[0]); e.data = int'(d1[0]); e.ir = int'(or1);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("n1[%0d].sel", n),   int'(s1),  e.sel);
      check($sformatf("n1[%0d].valid", n), int'(ov1), e.ov);
      check($sformatf("n1[%0d].data", n),  int'(od1), e.data);
      check($sformatf("n1[%0d].ready", n), int'(ir1), e.ir);
      prev_stall = v1[0] & ~or1;
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
